// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for receiver_top: drains received bytes into a FWFT FIFO,
// handshakes clear_flag after each frame and applies host config writes while the line is idle.
module uart_rx_ctrl #(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         ADDR_W         = 3,
    parameter int         TIMEOUT_CYCLES = 40000,
    parameter logic [5:0] CFG_RESET      = 6'b000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              flag_data_received,
    input  logic              flag_parity_error,
    input  logic [7:0]        data_exracted,
    output logic              clear_flag,
    output logic [5:0]        config_reg,
    input  logic              cfg_wr_en,
    input  logic [5:0]        cfg_wr_data,
    output logic              cfg_pending,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_CAPTURE,
        ST_CLEAR
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic              rx_s_prev;
    logic              rx_fall;
    logic [TO_W-1:0]   to_cnt;

    logic [8:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              pop;
    logic              capture;

    logic [5:0]        shadow;
    logic              cfg_apply;

    assign rx_fall = !rx_s && rx_s_prev;

    // Synchroniser, frame FSM and the registered clear_flag handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_prev  <= 1'b1;
            state      <= ST_IDLE;
            to_cnt     <= '0;
            clear_flag <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
            case (state)
                ST_IDLE: begin
                    if (flag_data_received) begin
                        state <= ST_CAPTURE;
                    end else if (rx_fall) begin
                        state  <= ST_BUSY;
                        to_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (flag_data_received) begin
                        state <= ST_CAPTURE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state      <= ST_CLEAR;
                    clear_flag <= 1'b1;
                end
                ST_CLEAR: begin
                    if (!flag_data_received) begin
                        state      <= ST_IDLE;
                        clear_flag <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    clear_flag <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign capture    = (state == ST_CAPTURE);
    assign pop        = rd_en && !fifo_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the captured byte.
    assign push       = capture && (!fifo_full || pop);

    assign rd_data = fifo_empty ? 8'h00 : mem[rd_ptr][7:0];
    assign rd_err  = fifo_empty ? 1'b0  : mem[rd_ptr][8];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (capture && !push) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; contents are only visible through the pointers, which are reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {flag_parity_error, data_exracted};
        end
    end

    assign cfg_apply = (state == ST_IDLE) && rx_s && !flag_data_received && cfg_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            config_reg  <= CFG_RESET;
            shadow      <= 6'b000000;
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_apply) begin
                config_reg <= shadow;
            end
            if (cfg_wr_en) begin
                shadow      <= cfg_wr_data;
                cfg_pending <= 1'b1;
            end else if (cfg_apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: reset, config apply rules, FIFO, overrun, timeout.
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 3;
    localparam int TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx;
    logic              flag_data_received;
    logic              flag_parity_error;
    logic [7:0]        data_exracted;
    logic              clear_flag;
    logic [5:0]        config_reg;
    logic              cfg_wr_en;
    logic [5:0]        cfg_wr_data;
    logic              cfg_pending;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              rd_err;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   fifo_count;
    logic              overrun;
    logic              overrun_clr;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CFG_RESET     (6'b000000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx                (rx),
        .flag_data_received(flag_data_received),
        .flag_parity_error (flag_parity_error),
        .data_exracted     (data_exracted),
        .clear_flag        (clear_flag),
        .config_reg        (config_reg),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_pending       (cfg_pending),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_err            (rd_err),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .fifo_count        (fifo_count),
        .overrun           (overrun),
        .overrun_clr       (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] v);
        cfg_wr_en   = 1'b1;
        cfg_wr_data = v;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Receiver model: raise the flag, hold it through the handshake, drop it.
    task automatic send_frame(input logic [7:0] d, input logic pe, input int hold, input logic pop_cap);
        flag_data_received = 1'b1;
        data_exracted      = d;
        flag_parity_error  = pe;
        tick();
        if (pop_cap) rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("clear_hi", clear_flag, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("clear_hold", clear_flag, 1);
        end
        flag_data_received = 1'b0;
        tick();
        check("clear_lo", clear_flag, 0);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; flag_data_received = 1'b0; flag_parity_error = 1'b0;
        data_exracted = 8'h00; cfg_wr_en = 1'b0; cfg_wr_data = 6'b0; rd_en = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_clear_flag", clear_flag, 0);
        check("rst_config", config_reg, 6'b000000);
        check("rst_pending", cfg_pending, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_err", rd_err, 0);
        check("rst_overrun", overrun, 0);

        // Idle config write: latched at the first edge, applied at the second.
        cfg_write(6'b101011);
        check("cfg_latched_pending", cfg_pending, 1);
        tick();
        check("cfg_applied", config_reg, 6'b101011);
        check("cfg_pending_clr", cfg_pending, 0);

        // Frame 0xA5 with explicit latency checks.
        flag_data_received = 1'b1; data_exracted = 8'hA5; flag_parity_error = 1'b0;
        tick();
        check("a5_count_capture", fifo_count, 0);
        check("a5_clear_capture", clear_flag, 0);
        tick();
        check("a5_count", fifo_count, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_err", rd_err, 0);
        check("a5_clear_hi", clear_flag, 1);
        tick();
        tick();
        check("a5_clear_held", clear_flag, 1);
        flag_data_received = 1'b0;
        tick();
        check("a5_clear_lo", clear_flag, 0);
        pop_one();
        check("a5_empty", fifo_empty, 1);
        check("a5_count0", fifo_count, 0);

        // Parity-error byte.
        send_frame(8'h55, 1'b1, 0, 1'b0);
        check("p55_data", rd_data, 8'h55);
        check("p55_err", rd_err, 1);
        pop_one();
        check("p55_empty", fifo_empty, 1);

        // Nine frames with no reads: the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 0, 1'b0);
        end
        check("ovr_full", fifo_full, 1);
        check("ovr_count", fifo_count, 8);
        check("ovr_flag", overrun, 1);
        check("ovr_head", rd_data, 8'h10);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Full FIFO with a pop during CAPTURE: push succeeds, no overrun.
        send_frame(8'h99, 1'b0, 0, 1'b1);
        check("fullpop_count", fifo_count, 8);
        check("fullpop_overrun", overrun, 0);
        for (int i = 1; i < 8; i++) begin
            check("drain_data", rd_data, 32'h10 + 32'(i));
            check("drain_err", rd_err, 0);
            pop_one();
        end
        check("drain_last", rd_data, 8'h99);
        pop_one();
        check("drain_empty", fifo_empty, 1);

        // Config write during a frame waits for the handshake to finish.
        rx = 1'b0;
        repeat (3) tick();
        cfg_write(6'b000011);
        tick();
        check("busy_cfg_hold", config_reg, 6'b101011);
        check("busy_cfg_pending", cfg_pending, 1);
        rx = 1'b1;
        repeat (3) tick();
        check("busy_cfg_hold2", config_reg, 6'b101011);
        send_frame(8'h3C, 1'b0, 1, 1'b0);
        check("frame_cfg_hold", config_reg, 6'b101011);
        tick();
        check("frame_cfg_apply", config_reg, 6'b000011);
        check("frame_cfg_pclr", cfg_pending, 0);

        // Two writes while pending: last one wins.
        rx = 1'b0;
        repeat (3) tick();
        cfg_write(6'b111000);
        cfg_write(6'b010101);
        rx = 1'b1;
        repeat (3) tick();
        check("last_cfg_hold", config_reg, 6'b000011);
        send_frame(8'hC3, 1'b0, 0, 1'b0);
        tick();
        check("last_cfg_apply", config_reg, 6'b010101);

        // Glitch: one low cycle enters BUSY, then the timeout returns to IDLE.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        tick();
        tick();
        cfg_write(6'b001100);
        repeat (TIMEOUT - 2) tick();
        check("to_cfg_hold", config_reg, 6'b010101);
        check("to_pending", cfg_pending, 1);
        tick();
        check("to_cfg_hold_exit", config_reg, 6'b010101);
        tick();
        check("to_cfg_apply", config_reg, 6'b001100);
        check("to_pending_clr", cfg_pending, 0);

        // Reset in CLEAR discards the handshake and the FIFO.
        check("pre_rst_count", fifo_count, 2);
        flag_data_received = 1'b1; data_exracted = 8'h77;
        tick();
        tick();
        check("clr_before_rst", clear_flag, 1);
        reset = 1'b1;
        tick();
        check("rst_clear_lo", clear_flag, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cfg_back", config_reg, 6'b000000);
        reset = 1'b0;
        flag_data_received = 1'b0;
        tick();
        check("post_rst_clear", clear_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
